// File: rtl/wb_sequencer_if.sv
// Handshake and control bundle between the instruction decoder (master) and the
// writeback sequencer (slave).
interface wb_sequencer_if;
   logic       start;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       div_zero;
   logic [3:0] mem_to_reg;
   logic [1:0] reg_dst;
   logic       reg_write;
   logic       hilo_write;
   logic       md_start;
   logic       mem_read;
   logic       busy;
   logic       done;
   logic       exception;

   modport master (
      output start, opcode, funct, div_zero,
      input  mem_to_reg, reg_dst, reg_write, hilo_write, md_start,
             mem_read, busy, done, exception
   );

   modport slave (
      input  start, opcode, funct, div_zero,
      output mem_to_reg, reg_dst, reg_write, hilo_write, md_start,
             mem_read, busy, done, exception
   );
endinterface

// File: rtl/wb_sequencer.sv
// Multicycle writeback controller: decodes one instruction, steps it through
// EXEC / MEM / MD phases and drives the writeback select and write strobes.
module wb_sequencer #(
   parameter int unsigned MEM_WAIT  = 2,
   parameter int unsigned MD_CYCLES = 32
) (
   input logic           clk,
   input logic           reset,
   wb_sequencer_if.slave bus_io
);

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_MEM, S_MD, S_WB, S_ERR
   } state_e;

   typedef enum logic [2:0] {
      C_ALU, C_LOAD, C_MULT, C_DIV, C_JR, C_BAD
   } cls_e;

   // Terminal counts; the counter starts at 0, so the last cycle is N-1.
   localparam logic [5:0] MEM_LAST = 6'(MEM_WAIT - 1);
   localparam logic [5:0] MD_LAST  = 6'(MD_CYCLES - 1);

   state_e     state_q, state_d;
   cls_e       cls_q, cls_d;
   logic [3:0] sel_q, sel_d;
   logic [1:0] dst_q, dst_d;
   logic [5:0] cnt_q, cnt_d;

   cls_e       decCls;
   logic [3:0] decSel;
   logic [1:0] decDst;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cls_q   <= C_ALU;
         sel_q   <= 4'd0;
         dst_q   <= 2'd0;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         sel_q   <= sel_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
      end
   end

   // Instruction decode; anything not listed falls into C_BAD with select/dst 0.
   always_comb begin
      decCls = C_BAD;
      decSel = 4'd0;
      decDst = 2'd0;
      case (bus_io.opcode)
         6'h00: begin
            decDst = 2'd1;
            decCls = C_ALU;
            case (bus_io.funct)
               6'h20, 6'h22, 6'h24:               decSel = 4'd0;
               6'h2a:                             decSel = 4'd4;
               6'h00, 6'h02, 6'h03, 6'h04, 6'h07: decSel = 4'd7;
               6'h10:                             decSel = 4'd2;
               6'h12:                             decSel = 4'd3;
               6'h18:                             decCls = C_MULT;
               6'h1a:                             decCls = C_DIV;
               6'h08:                             decCls = C_JR;
               default: begin
                  decCls = C_BAD;
                  decDst = 2'd0;
               end
            endcase
         end
         6'h08: decCls = C_ALU;
         6'h0a: begin
            decCls = C_ALU;
            decSel = 4'd4;
         end
         6'h0f: begin
            decCls = C_ALU;
            decSel = 4'd6;
         end
         6'h23, 6'h21, 6'h20: begin
            decCls = C_LOAD;
            decSel = 4'd1;
         end
         6'h03: begin
            decCls = C_ALU;
            decDst = 2'd2;
         end
         default: decCls = C_BAD;
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      sel_d   = sel_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;

      bus_io.mem_to_reg = 4'd0;
      bus_io.reg_dst    = 2'd0;
      bus_io.reg_write  = 1'b0;
      bus_io.hilo_write = 1'b0;
      bus_io.md_start   = 1'b0;
      bus_io.mem_read   = 1'b0;
      bus_io.busy       = (state_q != S_IDLE);
      bus_io.done       = 1'b0;
      bus_io.exception  = 1'b0;

      if (state_q inside {S_EXEC, S_MEM, S_MD, S_WB}) begin
         bus_io.mem_to_reg = sel_q;
         bus_io.reg_dst    = dst_q;
      end

      case (state_q)
         S_IDLE: begin
            if (bus_io.start) begin
               cls_d   = decCls;
               sel_d   = decSel;
               dst_d   = decDst;
               state_d = (decCls == C_BAD) ? S_ERR : S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d = 6'd0;
            case (cls_q)
               C_LOAD: state_d = S_MEM;
               C_MULT: begin
                  bus_io.md_start = 1'b1;
                  state_d         = S_MD;
               end
               C_DIV: begin
                  if (bus_io.div_zero) begin
                     state_d = S_ERR;
                  end else begin
                     bus_io.md_start = 1'b1;
                     state_d         = S_MD;
                  end
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            bus_io.mem_read = 1'b1;
            if (cnt_q == MEM_LAST) state_d = S_WB;
            else                   cnt_d   = cnt_q + 6'd1;
         end
         S_MD: begin
            if (cnt_q == MD_LAST) state_d = S_WB;
            else                  cnt_d   = cnt_q + 6'd1;
         end
         S_WB: begin
            bus_io.done       = 1'b1;
            bus_io.reg_write  = (cls_q == C_ALU) || (cls_q == C_LOAD);
            bus_io.hilo_write = (cls_q == C_MULT) || (cls_q == C_DIV);
            state_d           = S_IDLE;
         end
         S_ERR: begin
            bus_io.done      = 1'b1;
            bus_io.exception = 1'b1;
            state_d          = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: expected writeback results are queued at
// issue and checked by an independent monitor whenever done pulses.
module tb_wb_sequencer;

   typedef struct {
      int         startCyc;
      logic [3:0] sel;
      logic [1:0] dst;
      logic       rw;
      logic       hw;
      logic       exc;
      int         latency;
      int         mdStarts;
      int         memReads;
   } expect_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   passes;
   int   mdCnt;
   int   memCnt;
   expect_t sbQueue[$];

   wb_sequencer_if busIf ();

   wb_sequencer #(.MEM_WAIT(2), .MD_CYCLES(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (busIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
   endtask

   function automatic logic [12:0] allOutputs();
      return {busIf.mem_to_reg, busIf.reg_dst, busIf.reg_write, busIf.hilo_write,
              busIf.md_start, busIf.mem_read, busIf.busy, busIf.done, busIf.exception};
   endfunction

   // Monitor: independent of stimulus, compares against the queue head.
   always @(negedge clk) begin
      if (!reset) begin
         if (busIf.md_start) mdCnt++;
         if (busIf.mem_read) memCnt++;
         if (sbQueue.size() > 0 && !sbQueue[0].exc && cyc == sbQueue[0].startCyc + 1)
            checkOutput("execSelDst", {26'd0, busIf.mem_to_reg, busIf.reg_dst},
                        {26'd0, sbQueue[0].sel, sbQueue[0].dst});
         if (busIf.done) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
               expect_t e;
               e = sbQueue.pop_front();
               checkOutput("wbOutputs",
                           {23'd0, busIf.mem_to_reg, busIf.reg_dst, busIf.reg_write, busIf.hilo_write, busIf.exception},
                           {23'd0, e.sel, e.dst, e.rw, e.hw, e.exc});
               checkOutput("latency", 32'(cyc - e.startCyc), 32'(e.latency));
               checkOutput("sideCounts", {16'(mdCnt), 16'(memCnt)}, {16'(e.mdStarts), 16'(e.memReads)});
            end
            mdCnt  = 0;
            memCnt = 0;
         end
      end
   end

   // Issue one instruction, queue its expected result and wait for completion.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic dz,
                                input logic [3:0] sel, input logic [1:0] dst, input logic rw,
                                input logic hw, input logic exc, input int lat,
                                input int mds, input int mrs);
      expect_t e;
      int      waited;
      @(posedge clk); #1;
      e.startCyc = cyc;
      e.sel = sel; e.dst = dst; e.rw = rw; e.hw = hw; e.exc = exc;
      e.latency = lat; e.mdStarts = mds; e.memReads = mrs;
      sbQueue.push_back(e);
      busIf.opcode   = op;
      busIf.funct    = fn;
      busIf.div_zero = dz;
      busIf.start    = 1'b1;
      @(posedge clk); #1;
      busIf.start = 1'b0;
      waited = 0;
      while (busIf.done !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) checkOutput("doneTimeout", 32'd0, 32'd1);
   endtask

   initial begin
      cyc = 0; checks = 0; passes = 0; mdCnt = 0; memCnt = 0;
      reset = 1'b1;
      busIf.start = 1'b0; busIf.opcode = 6'd0; busIf.funct = 6'd0; busIf.div_zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("resetOutputs", {19'd0, allOutputs()}, 32'd0);
      #1 reset = 1'b0;

      $display("[TB] basic ALU, load and mult/div sequences");
      applyStimulus(6'h00, 6'h20, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0, 2, 0, 0);
      @(negedge clk);
      checkOutput("busyAfterAdd", {31'd0, busIf.busy}, 32'd0);
      applyStimulus(6'h23, 6'h00, 1'b0, 4'd1, 2'd0, 1'b1, 1'b0, 1'b0, 4, 0, 2);
      applyStimulus(6'h00, 6'h18, 1'b0, 4'd0, 2'd1, 1'b0, 1'b1, 1'b0, 34, 1, 0);
      applyStimulus(6'h00, 6'h10, 1'b0, 4'd2, 2'd1, 1'b1, 1'b0, 1'b0, 2, 0, 0);
      applyStimulus(6'h00, 6'h1a, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2, 0, 0);
      applyStimulus(6'h00, 6'h1a, 1'b0, 4'd0, 2'd1, 1'b0, 1'b1, 1'b0, 34, 1, 0);
      applyStimulus(6'h00, 6'h12, 1'b0, 4'd3, 2'd1, 1'b1, 1'b0, 1'b0, 2, 0, 0);
      applyStimulus(6'h00, 6'h2a, 1'b0, 4'd4, 2'd1, 1'b1, 1'b0, 1'b0, 2, 0, 0);
      applyStimulus(6'h00, 6'h03, 1'b0, 4'd7, 2'd1, 1'b1, 1'b0, 1'b0, 2, 0, 0);
      applyStimulus(6'h00, 6'h08, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2, 0, 0);
      applyStimulus(6'h03, 6'h00, 1'b0, 4'd0, 2'd2, 1'b1, 1'b0, 1'b0, 2, 0, 0);
      applyStimulus(6'h0a, 6'h00, 1'b0, 4'd4, 2'd0, 1'b1, 1'b0, 1'b0, 2, 0, 0);
      applyStimulus(6'h20, 6'h00, 1'b0, 4'd1, 2'd0, 1'b1, 1'b0, 1'b0, 4, 0, 2);
      applyStimulus(6'h00, 6'h3f, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1, 0, 0);

      $display("[TB] unknown opcode with start held while busy");
      @(posedge clk); #1;
      sbQueue.push_back('{startCyc: cyc, sel: 4'd0, dst: 2'd0, rw: 1'b0, hw: 1'b0,
                          exc: 1'b1, latency: 1, mdStarts: 0, memReads: 0});
      busIf.opcode = 6'h3f; busIf.funct = 6'h00; busIf.start = 1'b1;
      @(posedge clk); #1;
      busIf.opcode = 6'h00; busIf.funct = 6'h20;
      @(posedge clk); #1;
      busIf.start = 1'b0;
      @(negedge clk);
      checkOutput("idleAfterErr", {31'd0, busIf.busy}, 32'd0);
      repeat (4) @(posedge clk);

      $display("[TB] lui aborted by reset");
      @(posedge clk); #1;
      busIf.opcode = 6'h0f; busIf.funct = 6'h00; busIf.start = 1'b1;
      @(posedge clk); #1;
      busIf.start = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abortOutputs", {19'd0, allOutputs()}, 32'd0);
      repeat (3) @(posedge clk);
      applyStimulus(6'h00, 6'h20, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0, 2, 0, 0);

      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("queueDrained", 32'(sbQueue.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
